// File: rtl/imem_loader_pkg.sv
// Shared state encoding and framing constants for the instruction-memory loader.
// The CSUM encoding is always present, including builds without IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_CSUM  = 3'd4,
        S_FLUSH = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler: four accepted bytes form one 32-bit word.
// `word` already includes the byte being accepted, so the lane-3 cycle presents the full word.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    localparam int unsigned LANE_W = $clog2(BYTES_PER_WORD);

    logic [LANE_W-1:0] lane;
    logic [31:0]       shreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane  <= '0;
            shreg <= '0;
        end else if (clear) begin
            lane  <= '0;
            shreg <= '0;
        end else if (byte_en) begin
            lane  <= lane + 1'b1;
            shreg <= word;
        end
    end

    always_comb begin
        word = shreg;
        if (byte_en) begin
            word[lane*8 +: 8] = byte_in;
        end
    end

    assign word_done = byte_en && (lane == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: header word count, LE word assembly, sequential writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 8-bit data checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

    state_t          state, state_nx;
    logic [15:0]     count;
    logic [ADDR_W:0] index;
    logic            accept, byte_en, asm_clear, word_done, last_word;
    logic [15:0]     hdr_count;
    logic [31:0]     word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      sum;
`endif

    assign accept    = in_valid & in_ready;
    assign hdr_count = {in_data, count[7:0]};
    assign last_word = (16'(index) + 16'd1) == count;

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .byte_en   (byte_en),
        .byte_in   (in_data),
        .word      (word),
        .word_done (word_done)
    );

    always_comb begin
        state_nx  = state;
        asm_clear = 1'b0;
        byte_en   = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_nx = S_HDR0;
            S_HDR0: if (accept) state_nx = S_HDR1;
            S_HDR1: begin
                if (accept) begin
                    if (hdr_count == 16'd0 || 32'(hdr_count) > MAX_WORDS) begin
                        state_nx = S_ERR;
                    end else begin
                        state_nx  = S_DATA;
                        asm_clear = 1'b1;
                    end
                end
            end
            S_DATA: begin
                byte_en = accept;
                if (word_done && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nx = S_CSUM;
`else
                    state_nx = S_FLUSH;
`endif
                end
            end
            S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) state_nx = (in_data == sum) ? S_FLUSH : S_ERR;
`else
                state_nx = S_ERR;
`endif
            end
            S_FLUSH: state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            count      <= '0;
            index      <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            state   <= state_nx;
            imem_we <= 1'b0;
            if (state == S_HDR0 && accept) count[7:0] <= in_data;
            if (state == S_HDR1 && accept) begin
                count[15:8] <= in_data;
                index       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum         <= '0;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (byte_en) sum <= sum + in_data;
`endif
            if (word_done) begin
                imem_we    <= 1'b1;
                imem_waddr <= index[ADDR_W-1:0];
                imem_wdata <= word;
                index      <= index + 1'b1;
            end
            in_ready <= (state_nx == S_HDR0) || (state_nx == S_HDR1) ||
                        (state_nx == S_DATA) || (state_nx == S_CSUM);
            busy     <= (state_nx == S_HDR0) || (state_nx == S_HDR1) ||
                        (state_nx == S_DATA) || (state_nx == S_CSUM) ||
                        (state_nx == S_FLUSH);
            done     <= (state_nx == S_DONE);
            err      <= (state_nx == S_ERR);
            cpu_hold <= (state_nx != S_DONE);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-stream image model.
// Honours IMEM_LOADER_CHECKSUM_EN the same way as the RTL build.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;

    logic              clk, reset, start, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, imem_we, cpu_hold, busy, done, err;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [63:0] wr_q[$];
    logic [7:0]  img[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we) wr_q.push_back({32'(imem_waddr), imem_wdata});
    end

    task automatic check_reset_values();
        check("rst_in_ready", in_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_waddr", imem_waddr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
    endtask

    task automatic add_csum(input bit bad);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] s = 8'd0;
        for (int i = 2; i < img.size(); i++) s = s + img[i];
        img.push_back(s ^ {7'd0, bad});
`else
        if (bad) img.push_back(8'h00);
        else img.push_back(8'h00);
        void'(img.pop_back());
`endif
    endtask

    task automatic build(input int unsigned cnt, input bit bad);
        img.delete();
        img.push_back(cnt[7:0]);
        img.push_back(cnt[15:8]);
        if (cnt != 0 && cnt <= 2 ** ADDR_W) begin
            for (int unsigned i = 0; i < 4 * cnt; i++) img.push_back(8'($urandom));
            add_csum(bad);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned vpct, input bit noise);
        int unsigned t = 0;
        bit got = 1'b0;
        while (!got && t < 100) begin
            @(negedge clk);
            t++;
            in_data  = b;
            in_valid = ($urandom_range(99) < vpct);
            if (noise) start = 1'($urandom_range(1));
            if (in_valid && in_ready) got = 1'b1;
        end
        if (!got) check("send_timeout", 0, 1);
    endtask

    task automatic run_image(input int unsigned vpct, input bit noise);
        logic [63:0] exp_q[$];
        logic [15:0] cnt;
        bit          exp_err;
        int unsigned nsend;
        cnt     = {img[1], img[0]};
        exp_err = (cnt == 0) || (int'(cnt) > 2 ** ADDR_W);
        nsend   = exp_err ? 2 : img.size();
        if (!exp_err) begin
            for (int unsigned w = 0; w < cnt; w++)
                exp_q.push_back({32'(w), img[2+4*w+3], img[2+4*w+2], img[2+4*w+1], img[2+4*w]});
`ifdef IMEM_LOADER_CHECKSUM_EN
            begin
                logic [7:0] s = 8'd0;
                for (int unsigned i = 0; i < 4 * cnt; i++) s = s + img[2+i];
                exp_err = (img[img.size()-1] != s);
            end
`endif
        end
        wr_q.delete();
        pulse_start();
        for (int unsigned i = 0; i < nsend; i++) send_byte(img[i], vpct, noise);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        check("done_early", done, 0);
        check("err_timing", err, exp_err);
        @(negedge clk);
        check("done", done, !exp_err);
        check("err", err, exp_err);
        check("cpu_hold", cpu_hold, exp_err);
        check("busy_end", busy, 0);
        check("ready_end", in_ready, 0);
        check("nwrites", wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) check("write", wr_q[i], exp_q[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values();
        reset = 1'b0;

        // Directed two-word image
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
        add_csum(1'b0);
        run_image(100, 1'b0);
        if (wr_q.size() >= 2) begin
            check("tp_w0", wr_q[0], {32'd0, 32'h0000_0513});
            check("tp_w1", wr_q[1], {32'd1, 32'h00B5_05B3});
        end

        build(0, 1'b0);    run_image(100, 1'b0);
        build(3, 1'b0);    run_image(100, 1'b0);
        build(257, 1'b0);  run_image(100, 1'b0);
        build(256, 1'b0);  run_image(100, 1'b0);
        if (wr_q.size() > 0) check("last_addr", wr_q[wr_q.size()-1][63:32], 32'hFF);
        build(3, 1'b0);    run_image(50, 1'b1);

        // Reset after the sixth data byte, then a clean reload
        build(3, 1'b0);
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(img[i], 100, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        build(3, 1'b0);    run_image(100, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        img = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        run_image(100, 1'b0);
        check("cs_ok_done", done, 1);
        img = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        run_image(100, 1'b0);
        check("cs_bad_err", err, 1);
        if (wr_q.size() > 0) check("cs_bad_w0", wr_q[0], {32'd0, 32'h0403_0201});
`endif

        for (int k = 0; k < 6; k++) begin
            build($urandom_range(1, 8), 1'($urandom_range(1)));
            run_image($urandom_range(30, 100), 1'($urandom_range(1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
